// File: rtl/sprite_attr_arbiter.sv
// Sprite attribute RAM arbiter: per-line sprite fetch for the render path,
// plus host attribute writes buffered in a FIFO and applied only in vblank
// so sprite attributes change atomically per frame.
module sprite_attr_arbiter #(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned ATTR_W      = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned H_ACTIVE    = 1024,
    parameter int unsigned V_ACTIVE    = 768,
    parameter int unsigned V_TOTAL     = 806,
    localparam int unsigned IDX_W      = $clog2(NUM_SPRITES)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [12:0]       x_i,
    input  logic [12:0]       y_i,
    input  logic              host_wr_valid_i,
    output logic              host_wr_ready_o,
    input  logic [IDX_W-1:0]  host_wr_idx_i,
    input  logic [ATTR_W-1:0] host_wr_data_i,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [IDX_W-1:0]  ram_addr_o,
    output logic [ATTR_W-1:0] ram_wdata_o,
    input  logic [ATTR_W-1:0] ram_rdata_i,
    output logic              line_attr_valid_o,
    output logic [IDX_W-1:0]  line_attr_idx_o,
    output logic [ATTR_W-1:0] line_attr_data_o,
    output logic              frame_commit_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [12:0]      H_TRIG   = 13'(H_ACTIVE);
    localparam logic [12:0]      V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0]      V_PRE    = 13'(V_ACTIVE - 1);
    localparam logic [12:0]      V_LAST   = 13'(V_TOTAL - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q;

    // Host write FIFO storage and pointers
    logic [IDX_W-1:0]  fifo_idx_q  [FIFO_DEPTH];
    logic [ATTR_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              ram_en_q;
    logic              ram_we_q;
    logic [IDX_W-1:0]  ram_addr_q;
    logic [ATTR_W-1:0] ram_wdata_q;
    logic              line_valid_q;
    logic [IDX_W-1:0]  line_idx_q;
    logic              commit_q;
    logic              commit_done_q;

    logic fifo_empty_c;
    logic fifo_full_c;
    logic push_c;
    logic pop_c;
    logic trigger_c;
    logic vblank_c;
    logic drain_zone_c;

    // Beam decode: fetch trigger on the line before each visible line
    always_comb begin
        trigger_c    = (x_i == H_TRIG) && ((y_i < V_PRE) || (y_i == V_LAST));
        vblank_c     = (y_i >= V_ACT);
        drain_zone_c = vblank_c && (y_i < V_LAST);
    end

    // FIFO status and handshake; a pop never frees a slot for the same-cycle push
    always_comb begin
        fifo_empty_c    = (count_q == '0);
        fifo_full_c     = (count_q == FULL_CNT);
        host_wr_ready_o = !fifo_full_c && !reset_i;
        push_c          = host_wr_valid_i && host_wr_ready_o;
        pop_c           = (state_q != S_FETCH) && drain_zone_c && !fifo_empty_c && !trigger_c;
    end

    // FIFO entry storage (no reset needed, guarded by count)
    always_ff @(posedge clock_i) begin
        if (push_c) begin
            fifo_idx_q[wr_ptr_q]  <= host_wr_idx_i;
            fifo_data_q[wr_ptr_q] <= host_wr_data_i;
        end
    end

    // FIFO pointers and occupancy; reset discards all pending writes
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Arbiter FSM with registered RAM port; the fetch trigger beats draining
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DRAIN: begin
                    if (trigger_c) begin
                        state_q    <= S_FETCH;
                        ram_en_q   <= 1'b1;
                        ram_addr_q <= '0;
                    end else if (pop_c) begin
                        state_q     <= S_DRAIN;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= fifo_idx_q[rd_ptr_q];
                        ram_wdata_q <= fifo_data_q[rd_ptr_q];
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (ram_addr_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                    end else begin
                        ram_en_q   <= 1'b1;
                        ram_addr_q <= ram_addr_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Line attribute valid/index track the read issued one cycle earlier
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            line_valid_q <= 1'b0;
            line_idx_q   <= '0;
        end else begin
            line_valid_q <= ram_en_q && !ram_we_q;
            if (ram_en_q && !ram_we_q) begin
                line_idx_q <= ram_addr_q;
            end
        end
    end

    // Once-per-frame commit pulse when the FIFO is first seen empty in vblank
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            commit_q      <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            commit_q <= vblank_c && fifo_empty_c && !commit_done_q;
            if (!vblank_c) begin
                commit_done_q <= 1'b0;
            end else if (fifo_empty_c) begin
                commit_done_q <= 1'b1;
            end
        end
    end

    assign ram_en_o          = ram_en_q;
    assign ram_we_o          = ram_we_q;
    assign ram_addr_o        = ram_addr_q;
    assign ram_wdata_o       = ram_wdata_q;
    assign line_attr_valid_o = line_valid_q;
    assign line_attr_idx_o   = line_idx_q;
    assign line_attr_data_o  = line_valid_q ? ram_rdata_i : '0;
    assign frame_commit_o    = commit_q;

endmodule

// File: tb/tb_sprite_attr_arbiter.sv
// Randomized bench for sprite_attr_arbiter: compressed raster, random host
// writes, and a transaction-level reference model of FIFO, RAM and fetches.
module tb_sprite_attr_arbiter;

    localparam int unsigned NS = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned FD = 4;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [12:0]   x;
    logic [12:0]   y;
    logic          wv;
    logic          wr;
    logic [IW-1:0] wi;
    logic [AW-1:0] wd;
    logic          en;
    logic          we;
    logic [IW-1:0] addr;
    logic [AW-1:0] wdat;
    logic [AW-1:0] rdata;
    logic          lv;
    logic [IW-1:0] li;
    logic [AW-1:0] ld;
    logic          fc;
    logic          load_ram;

    always #5 clk = ~clk;

    sprite_attr_arbiter dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .x_i               (x),
        .y_i               (y),
        .host_wr_valid_i   (wv),
        .host_wr_ready_o   (wr),
        .host_wr_idx_i     (wi),
        .host_wr_data_i    (wd),
        .ram_en_o          (en),
        .ram_we_o          (we),
        .ram_addr_o        (addr),
        .ram_wdata_o       (wdat),
        .ram_rdata_i       (rdata),
        .line_attr_valid_o (lv),
        .line_attr_idx_o   (li),
        .line_attr_data_o  (ld),
        .frame_commit_o    (fc)
    );

    // Single-port synchronous attribute RAM, preloaded with idx*0x11
    logic [AW-1:0] ram [NS];
    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < int'(NS); i++) ram[i] <= AW'(i * 32'h11);
        end else if (en) begin
            if (we) ram[addr] <= wdat;
            else    rdata     <= ram[addr];
        end
    end

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [AW-1:0] data;
    } wr_t;

    int            checks = 0;
    int            errors = 0;

    // Reference model state
    logic [AW-1:0] ref_ram [NS];
    wr_t           q[$];
    int            fk;
    logic          done;
    logic          e_known;
    logic          e_zero;
    logic          e_en, e_we, e_lv, e_fc;
    logic [IW-1:0] e_addr, e_li;
    logic [AW-1:0] e_wd, e_ld;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model
    task automatic step(input logic r, input int xv, input int yv);
        logic trig;
        logic pop;
        logic rdy;
        int   nfk;
        int   sz0;
        int   pct;
        wr_t  w;
        if (e_known) begin
            check_eq("ram_en", en, e_en);
            check_eq("ram_we", we, e_we);
            if (e_en || e_zero) check_eq("ram_addr", addr, e_addr);
            if (e_we || e_zero) check_eq("ram_wdata", wdat, e_wd);
            check_eq("line_valid", lv, e_lv);
            if (e_lv || e_zero) begin
                check_eq("line_idx", li, e_li);
                check_eq("line_data", ld, e_ld);
            end
            check_eq("frame_commit", fc, e_fc);
        end

        pct = (yv < 768) ? 50 : 15;
        rst = r;
        x   = 13'(xv);
        y   = 13'(yv);
        wv  = ($urandom_range(0, 99) < pct);
        wi  = IW'($urandom_range(0, NS - 1));
        wd  = $urandom;
        rdy = !r && (q.size() < int'(FD));
        #1;
        check_eq("host_ready", wr, rdy);

        e_known = 1'b1;
        e_en = 1'b0; e_we = 1'b0; e_lv = 1'b0; e_fc = 1'b0; e_zero = 1'b0;
        e_addr = '0; e_li = '0; e_wd = '0; e_ld = '0;
        if (r) begin
            q.delete();
            fk     = -1;
            done   = 1'b0;
            e_zero = 1'b1;
        end else begin
            trig = (xv == 1024) && ((yv < 767) || (yv == 805));
            sz0  = q.size();
            if (fk >= 0)   nfk = (fk < int'(NS) - 1) ? fk + 1 : -1;
            else if (trig) nfk = 0;
            else           nfk = -1;
            pop = (fk < 0) && !trig && (yv >= 768) && (yv < 805) && (sz0 > 0);
            if (fk >= 0) begin
                e_lv = 1'b1;
                e_li = IW'(fk);
                e_ld = ref_ram[fk];
            end
            if (nfk >= 0) begin
                e_en   = 1'b1;
                e_addr = IW'(nfk);
            end
            if (pop) begin
                w      = q.pop_front();
                e_en   = 1'b1;
                e_we   = 1'b1;
                e_addr = w.idx;
                e_wd   = w.data;
                ref_ram[w.idx] = w.data;
            end
            if (yv >= 768) begin
                if (sz0 == 0 && !done) e_fc = 1'b1;
                if (sz0 == 0) done = 1'b1;
            end else begin
                done = 1'b0;
            end
            if (wv && rdy) q.push_back('{idx: wi, data: wd});
            fk = nfk;
        end
        @(negedge clk);
    endtask

    // One raster line: a few active columns, then optionally the hblank window
    task automatic run_line(input int yv, input int pre, input bit hb, input int rst_at);
        int k;
        k = 0;
        for (int i = 0; i < pre; i++) begin
            step(k == rst_at, i, yv);
            k++;
        end
        if (hb) begin
            for (int i = 0; i < 12; i++) begin
                step(k == rst_at, 1024 + i, yv);
                k++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; wv = 1'b0; wi = '0; wd = '0;
        load_ram = 1'b1;
        fk = -1; done = 1'b0; e_known = 1'b0; e_zero = 1'b0;
        e_en = 1'b0; e_we = 1'b0; e_lv = 1'b0; e_fc = 1'b0;
        e_addr = '0; e_li = '0; e_wd = '0; e_ld = '0;
        for (int i = 0; i < int'(NS); i++) ref_ram[i] = AW'(i * 32'h11);

        step(1'b1, 0, 0);
        load_ram = 1'b0;
        step(1'b1, 0, 0);
        step(1'b1, 0, 0);

        for (int f = 0; f < 8; f++) begin
            run_line(0, 6, 1'b1, -1);
            run_line(1, 6, 1'b1, (f == 3) ? 10 : -1);
            run_line(2, 6, 1'b1, -1);
            run_line(int'($urandom_range(3, 765)), 6, 1'b1, -1);
            run_line(766, 6, 1'b1, -1);
            run_line(767, 6, 1'b1, -1);
            if (f % 3 == 2) begin
                run_line(804, 2, 1'b0, -1);
            end else begin
                run_line(768, 6, 1'b1, (f == 5) ? 1 : -1);
                run_line(769, 6, 1'b1, -1);
                run_line(790, 6, 1'b1, -1);
                run_line(804, 6, 1'b1, -1);
            end
            run_line(805, 6, 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
